// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_WAIT
    } rx_state_t;

    localparam int OVERSAMPLE    = 16;
    localparam int SAMPLE_MID    = 7;
    localparam int SAMPLE_DECIDE = 9;
    localparam int DATA_BITS     = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; a push into a full FIFO is dropped unless a pop
// frees the head slot in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates the full and empty cases when the indices match.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling with 3-sample
// majority vote, framing-error detection and a show-ahead receive FIFO.
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 54,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_overrun,
    output logic       busy
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]  T_MID    = 4'(SAMPLE_MID);
    localparam logic [3:0]  T_MID1   = 4'(SAMPLE_MID + 1);
    localparam logic [3:0]  T_DEC    = 4'(SAMPLE_DECIDE);
    localparam logic [3:0]  T_LAST   = 4'(OVERSAMPLE - 1);
    localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);

    rx_state_t   state;
    rx_state_t   state_next;
    logic        sync_q;
    logic        s_rxd;
    logic [15:0] pre_cnt;
    logic        tick;
    logic [3:0]  tcnt;
    logic [2:0]  bit_idx;
    logic        samp_a;
    logic        samp_b;
    logic        vote;
    logic [7:0]  shreg;
    logic        decide;
    logic        bit_end;
    logic        start_det;
    logic        shift_en;
    logic        stop_ok;
    logic        stop_bad;
    logic        push_q;
    logic        ferr_q;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_drop;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 1'b1;
            s_rxd  <= 1'b1;
        end else begin
            sync_q <= rxd;
            s_rxd  <= sync_q;
        end
    end

    assign tick    = (pre_cnt == DIV_LAST);
    assign decide  = tick && (tcnt == T_DEC);
    assign bit_end = tick && (tcnt == T_LAST);
    assign vote    = majority3(samp_a, samp_b, s_rxd);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (!s_rxd) state_next = START;
            START:    if (decide && vote) state_next = IDLE;
                      else if (bit_end) state_next = DATA;
            DATA:     if (bit_end && bit_idx == BIT_LAST) state_next = STOP;
            STOP:     if (decide) state_next = vote ? IDLE : BRK_WAIT;
            BRK_WAIT: if (s_rxd) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        start_det = 1'b0;
        shift_en  = 1'b0;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE:    start_det = !s_rxd;
            DATA:    shift_en  = decide;
            STOP: begin
                stop_ok  = decide && vote;
                stop_bad = decide && !vote;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    // Prescaler restarts on the start edge so every tick lands on a fixed bit phase.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pre_cnt <= '0;
            tcnt    <= '0;
            bit_idx <= '0;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
            shreg   <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            push_q <= stop_ok;
            ferr_q <= stop_bad;
            if (start_det) begin
                pre_cnt <= '0;
                tcnt    <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
                tcnt    <= tcnt + 4'd1;
            end else begin
                pre_cnt <= pre_cnt + 16'd1;
            end
            if (tick && tcnt == T_MID)  samp_a <= s_rxd;
            if (tick && tcnt == T_MID1) samp_b <= s_rxd;
            if (shift_en) shreg <= {vote, shreg[7:1]};
            if (state == START && bit_end) begin
                bit_idx <= '0;
            end else if (state == DATA && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    assign frame_err = ferr_q;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (push_q),
        .pop    (rx_ready),
        .wdata  (shreg),
        .rdata  (rx_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .drop   (fifo_drop)
    );

    assign rx_valid = !fifo_empty;

    // A new drop beats a same-cycle clear so no overrun is ever lost.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overrun <= 1'b0;
        end else if (fifo_drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Bench for uart_rx_unit: serial frames driven bit by bit, received bytes
// checked in order against an expected-byte queue.
module tb_uart_rx_unit;

    localparam int CLK_DIV  = 4;
    localparam int DEPTH    = 4;
    localparam int BIT_CLKS = 16 * CLK_DIV;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b1;
    logic       clr_overrun = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q[$];
    int         ferr_seen = 0;
    int         ferr_exp = 0;
    logic       ferr_prev = 1'b0;
    logic       ovr_exp = 1'b0;

    always #5 clock = ~clock;

    uart_rx_unit #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: compares every handshaked byte against the queue head and counts frame_err pulses.
    always @(negedge clock) begin
        #1;
        if (resetn && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rx_byte: got unexpected 0x%0h, expected no byte", rx_data);
            end else begin
                check("rx_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (frame_err && !ferr_prev) ferr_seen++;
        if (frame_err && ferr_prev) begin
            tests_run++;
            tests_failed++;
            $display("FAIL frame_err_width: got >1 cycle, expected 1 cycle");
        end
        ferr_prev = frame_err;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        rxd = 1'b0;
        tick_n(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick_n(BIT_CLKS);
        end
        rxd = stop_val;
        tick_n(8);
        check("busy_early_stop", {31'd0, busy}, 32'd1);
        tick_n(BIT_CLKS - 8);
        check("busy_end_stop", {31'd0, busy}, {31'd0, !stop_val});
    endtask

    // Reference: the FIFO holds whatever has been queued and not yet read, so
    // a byte arriving with rx_ready low and DEPTH bytes pending is lost.
    task automatic send_good(input logic [7:0] b);
        if (rx_ready || exp_q.size() < DEPTH) exp_q.push_back(b);
        else ovr_exp = 1'b1;
        send_frame(b, 1'b1);
    endtask

    task automatic send_bad(input logic [7:0] b, input int hold);
        ferr_exp++;
        send_frame(b, 1'b0);
        tick_n(hold);
        check("brk_wait_held", {31'd0, busy}, 32'd1);
        rxd = 1'b1;
        tick_n(6);
        check("brk_wait_release", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({name, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        check({name, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({name, "_overrun"}, {31'd0, overrun}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic drain(input string name);
        rx_ready = 1'b1;
        tick_n(10);
        check({name, "_queue_empty"}, exp_q.size(), 32'd0);
        check({name, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    endtask

    initial begin
        #900000;
        tests_failed++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        int n;
        resetn = 1'b0;
        tick_n(3);
        check_reset_outputs("reset");
        resetn = 1'b1;
        tick_n(5);

        // Single clean frame
        send_good(8'h55);
        tick_n(4);
        check("b55_queue_empty", exp_q.size(), 32'd0);
        check("b55_no_frame_err", ferr_seen, 32'd0);

        // Short low glitch on the idle line
        rxd = 1'b0;
        tick_n(10);
        check("glitch_start_entered", {31'd0, busy}, 32'd1);
        tick_n(10);
        rxd = 1'b1;
        tick_n(40);
        check("glitch_back_idle", {31'd0, busy}, 32'd0);
        check("glitch_no_frame_err", ferr_seen, 32'd0);
        check("glitch_no_push", {31'd0, rx_valid}, 32'd0);

        // Bad stop bit followed by a held break
        send_bad(8'hA3, 200);
        tick_n(4);
        check("break_frame_err_count", ferr_seen, ferr_exp);
        check("break_no_push", {31'd0, rx_valid}, 32'd0);

        // Overrun: five bytes into a four-entry FIFO with no reader
        rx_ready = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            send_good(8'(b));
            if (b == 4) check("overrun_after_4", {31'd0, overrun}, 32'd0);
        end
        tick_n(4);
        check("overrun_after_5", {31'd0, overrun}, {31'd0, ovr_exp});
        drain("overrun_drain");
        clr_overrun = 1'b1;
        tick_n(1);
        clr_overrun = 1'b0;
        ovr_exp = 1'b0;
        check("overrun_cleared", {31'd0, overrun}, 32'd0);

        // Full FIFO with a pop landing exactly on the push cycle
        rx_ready = 1'b0;
        for (int b = 0; b < 4; b++) send_good(8'h11 + 8'(b));
        exp_q.push_back(8'h77);
        fork
            send_frame(8'h77, 1'b1);
            begin
                n = 0;
                while (!busy && n < 200) begin tick_n(1); n++; end
                check("timed_pop_busy_rise", {31'd0, busy}, 32'd1);
                n = 0;
                while (busy && n < 1000) begin tick_n(1); n++; end
                check("timed_pop_busy_fall", {31'd0, busy}, 32'd0);
                rx_ready = 1'b1;
                tick_n(1);
                rx_ready = 1'b0;
            end
        join
        tick_n(4);
        check("timed_pop_no_overrun", {31'd0, overrun}, 32'd0);
        check("timed_pop_pending", exp_q.size(), 32'd4);
        drain("timed_pop_drain");

        // Reset in the middle of a frame, with the FIFO full and overrun set
        rx_ready = 1'b0;
        for (int b = 0; b < 5; b++) send_good(8'($urandom_range(0, 255)));
        tick_n(4);
        check("pre_reset_overrun", {31'd0, overrun}, 32'd1);
        rxd = 1'b0;
        tick_n(BIT_CLKS);
        for (int i = 0; i < 5; i++) begin
            rxd = (8'h3C >> i) & 8'h01;
            tick_n(i == 4 ? BIT_CLKS / 2 : BIT_CLKS);
        end
        resetn = 1'b0;
        rxd = 1'b1;
        exp_q.delete();
        ovr_exp = 1'b0;
        #1;
        check_reset_outputs("mid_frame_reset");
        tick_n(5);
        resetn = 1'b1;
        rx_ready = 1'b1;
        tick_n(10);
        send_good(8'hC3);
        tick_n(4);
        check("after_reset_queue_empty", exp_q.size(), 32'd0);

        // Randomized frames: random data, gaps and occasional bad stop bits
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 3) == 0) send_bad(8'($urandom_range(0, 255)), $urandom_range(20, 200));
            else send_good(8'($urandom_range(0, 255)));
            tick_n($urandom_range(0, 100));
        end
        tick_n(10);
        check("random_queue_empty", exp_q.size(), 32'd0);
        check("random_frame_err_count", ferr_seen, ferr_exp);
        check("random_no_overrun", {31'd0, overrun}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_rx_unit.md
Name: uart_rx_unit

Overview:
- UART receiver: consumes the SoC's asynchronous serial input pin (externalPins_uart_rx) and delivers bytes to the on-chip UART register block.
- 8N1 framing, 16x oversampling, majority-vote bit sampling, framing-error detection.
- Small show-ahead receive FIFO with a valid/ready read port.
- Sits between the pad and the UART register/interrupt logic.

Parameters:
- CLK_DIV, 54, clock cycles per oversample tick (1/16 bit); 54 gives ~115200 baud at 100 MHz; legal range 2..65535.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.

Ports:
- clock, input, 1, single system clock.
- resetn, input, 1, asynchronous active-low reset.
- rxd, input, 1, raw serial line, asynchronous, idle high.
- rx_data, output, 8, FIFO head byte; valid when rx_valid.
- rx_valid, output, 1, FIFO not empty.
- rx_ready, input, 1, consumer pops the head on rx_valid & rx_ready.
- frame_err, output, 1, one-cycle pulse when a stop bit samples low.
- overrun, output, 1, sticky: a byte was dropped because the FIFO was full.
- clr_overrun, input, 1, synchronous clear of overrun.
- busy, output, 1, FSM not in IDLE.

Behaviour:
Reset (asynchronous, resetn low):
- Synchronizer flops = 1, FSM = IDLE, prescaler = 0, FIFO empty.
- rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0.
- Reset mid-frame abandons the frame; no partial byte is ever pushed.

Input path and timing:
- rxd passes through a 2-flop synchronizer; the FSM sees only the synced value s_rxd (2-cycle latency).
- Prescaler counts 0..CLK_DIV-1; a tick fires when the count equals CLK_DIV-1.
- Prescaler is forced to 0 on the IDLE->START transition.
- Tick counter tcnt is 4 bits and wraps 15->0; bit period = 16 ticks.
- Majority vote of s_rxd sampled at tcnt 7, 8 and 9; the voted value is used at tcnt 9.

FSM states:
- IDLE: s_rxd == 0 -> START, tcnt = 0.
- START: at tcnt 9, vote == 1 -> IDLE (glitch rejected, nothing reported). At tcnt 15 -> DATA, bit index = 0.
- DATA: at tcnt 9, shift the vote into the shift register, LSB first. At tcnt 15 with bit index 7 -> STOP, otherwise increment the bit index.
- STOP: at tcnt 9, vote == 1 -> push the byte and go to IDLE (early return allows resync to a back-to-back start). Vote == 0 -> pulse frame_err for one clock, discard the byte, go to BRK_WAIT.
- BRK_WAIT: wait for s_rxd == 1, then go to IDLE. This stops a held-low break line from re-triggering START.

FIFO:
- Push happens in the clock after the STOP decision; rx_valid is high the following cycle.
- Show-ahead: rx_data always equals the head entry.
- Push when full with no simultaneous pop: byte dropped, overrun set.
- Push when full with a simultaneous pop: accepted, no overrun.
- Pop when empty is ignored.
- Pointers are log2(FIFO_DEPTH)+1 bits wide; the MSB distinguishes full from empty.
- clr_overrun in the same cycle as a new overrun: set wins.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, BRK_WAIT};
  - OVERSAMPLE = 16, SAMPLE_MID = 7, SAMPLE_DECIDE = 9;
  - DATA_BITS = 8.
- One sub-module: uart_rx_fifo (parameterised depth, width 8, push/pop/full/empty, show-ahead).
- The synchronizer, prescaler and FSM stay in uart_rx_unit.

Test Plan:
All cases use CLK_DIV = 4 (1 bit = 64 clocks), rx_ready = 1 unless stated.
- Send 0x55 8N1 -> rx_valid rises once with rx_data = 0x55; frame_err never pulses; busy drops at mid-stop.
- 20-clock low glitch on idle rxd -> START entered then abandoned; no push, no frame_err; FSM back in IDLE by tcnt 9.
- Send 0xA3 with the stop bit driven low, then hold rxd low 200 clocks, then release -> exactly one frame_err pulse, no push, FSM in BRK_WAIT until the line rises, then IDLE.
- rx_ready = 0, send 0x01..0x05 back-to-back -> overrun = 1 after the 5th byte. Then raise rx_ready -> read 0x01, 0x02, 0x03, 0x04 in order, and rx_valid = 0 afterwards. Pulse clr_overrun -> overrun = 0.
- Full FIFO, pop on the exact push cycle of a 5th byte 0x77 -> no overrun, 0x77 is last in the read order.
- Assert resetn low at data bit 4 of 0x3C, release, then send 0xC3 -> only 0xC3 is received; all outputs are at reset values during reset.
